unsigned_seq_divider_16by8: RTL and testbench

// - Iterative restoring divider: unsigned NW-bit dividend / DW-bit divisor -> NW-bit quotient, DW-bit remainder.
// - Inverse datapath of the 8x8 unsigned multiplier family.
// - Recovers operands from products, and serves as exact reference for error/fval checks of approximate multipliers.
// - Sits behind a valid/ready producer; one division in flight; one quotient bit per cycle.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_restore_step.sv | 19 +
 rtl/unsigned_seq_divider_16by8.sv | 134 +++++++++++++
 tb/tb_unsigned_seq_divider_16by8.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential unsigned divider family.
package div_pkg;

   localparam int DIV_DW = 8;
   localparam int DIV_NW = 2 * DIV_DW;
   localparam int DIV_CW = $clog2(DIV_NW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_restore_step #(
   parameter int DW = 8
) (
   input  logic [DW:0]   p_in,
   input  logic          bit_in,
   input  logic [DW-1:0] divisor,
   output logic [DW:0]   p_out,
   output logic          q_bit
);

   // Compare on the full shifted value so a caller that lets P[DW] be set
   // still gets a correct decision; the result always fits back in DW+1 bits.
   assign q_bit = ({p_in, bit_in} >= {2'b00, divisor});
   assign p_out = q_bit ? (DW+1)'({p_in, bit_in} - {2'b00, divisor})
                        : (DW+1)'({p_in, bit_in});

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Iterative restoring divider, NW-bit dividend by DW-bit divisor, one quotient
// bit per cycle behind a valid/ready handshake with a single op in flight.
//
// state  | meaning
// S_IDLE | ready for operands
// S_BUSY | shifting out quotient bits, counter counts down to 0
// S_DONE | result held on outputs until the consumer takes it
module unsigned_seq_divider_16by8
   import div_pkg::*;
#(
   parameter  int DW = DIV_DW,
   localparam int NW = 2 * DW,
   localparam int CW = $clog2(NW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          div_by_zero
);

   div_state_t    state;
   div_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [DW:0]   p_q;
   logic [DW:0]   p_nxt;
   logic [NW-1:0] dq;
   logic [NW-1:0] dq_nxt;
   logic [DW-1:0] dvs;
   logic          q_bit;

   div_restore_step #(.DW(DW)) u_step (
      .p_in    (p_q),
      .bit_in  (dq[NW-1]),
      .divisor (dvs),
      .p_out   (p_nxt),
      .q_bit   (q_bit)
   );

   // Dividend bits leave at the MSB while quotient bits enter at the LSB,
   // so after NW steps the register holds the full quotient.
   assign dq_nxt = {dq[NW-2:0], q_bit};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt = (divisor == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt == '0) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs; no accept while a result is still waiting.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, iteration datapath, step counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         p_q         <= '0;
         dq          <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  dvs <= divisor;
                  dq  <= dividend;
                  p_q <= '0;
                  cnt <= CW'(NW - 1);
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[DW-1:0];
                     div_by_zero <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               p_q <= p_nxt;
               dq  <= dq_nxt;
               if (cnt == '0) begin
                  quotient    <= dq_nxt;
                  remainder   <= p_nxt[DW-1:0];
                  div_by_zero <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Scoreboard bench for the sequential 16/8 divider.
module tb_unsigned_seq_divider_16by8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   unsigned_seq_divider_16by8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] x;
      logic [7:0]  y;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
      int unsigned acc;
      int unsigned lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Consumer side: out_ready changes just after the rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares presented results against the head of the scoreboard.
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = sb[0];
               if (!seen) begin
                  chk("latency", cyc - e.acc + 1, e.lat);
                  seen = 1'b1;
               end
               chk(out_ready ? "quotient"  : "hold_quotient",  32'(quotient),    32'(e.q));
               chk(out_ready ? "remainder" : "hold_remainder", 32'(remainder),   32'(e.r));
               chk(out_ready ? "dbz"       : "hold_dbz",       32'(div_by_zero), 32'(e.z));
               chk("in_ready_in_done", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  if (!e.z) begin
                     chk("identity", 32'(quotient) * 32'(e.y) + 32'(remainder), 32'(e.x));
                     chk("rem_lt_div", 32'(remainder < e.y), 32'd1);
                  end
                  void'(sb.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_in_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send(input logic [15:0] x, input logic [7:0] y,
                       input logic [15:0] eq, input logic [7:0] er, input logic ez);
      exp_t e;
      wait_in_ready();
      if (!in_ready) return;
      dividend = x;
      divisor  = y;
      in_valid = 1'b1;
      e.x   = x;
      e.y   = y;
      e.q   = eq;
      e.r   = er;
      e.z   = ez;
      e.acc = cyc + 1;
      e.lat = (y == 8'd0) ? 1 : 17;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   typedef struct {
      logic [15:0] x;
      logic [7:0]  y;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } vec_t;

   vec_t vecs[11] = '{
      '{16'd1000, 8'd7,   16'd142,  8'd6,   1'b0},
      '{16'hFFFF, 8'h01,  16'hFFFF, 8'h00,  1'b0},
      '{16'hFFFF, 8'hFF,  16'h0101, 8'h00,  1'b0},
      '{16'h0005, 8'h09,  16'h0000, 8'h05,  1'b0},
      '{16'h1234, 8'h00,  16'hFFFF, 8'h34,  1'b1},
      '{16'h0000, 8'h05,  16'h0000, 8'h00,  1'b0},
      '{16'h00FF, 8'h10,  16'h000F, 8'h0F,  1'b0},
      '{16'h8000, 8'h80,  16'h0100, 8'h00,  1'b0},
      '{16'hFFFE, 8'hFF,  16'h0100, 8'hFE,  1'b0},
      '{16'h00AB, 8'h00,  16'hFFFF, 8'hAB,  1'b1},
      '{16'hFFFF, 8'h00,  16'hFFFF, 8'hFF,  1'b1}
   };

   initial begin
      int n;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),    32'd1);
      chk("rst_out_valid", 32'(out_valid),   32'd0);
      chk("rst_quotient",  32'(quotient),    32'd0);
      chk("rst_remainder", 32'(remainder),   32'd0);
      chk("rst_dbz",       32'(div_by_zero), 32'd0);
      rst_n = 1'b1;

      // Directed vectors, consumer always ready.
      ready_mode = 1;
      foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].z);
      drain();

      // Backpressure: result held while a competing request is presented.
      ready_mode = 0;
      @(negedge clk);
      @(negedge clk);
      send(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      dividend = 16'h4321;
      divisor  = 8'h03;
      in_valid = 1'b1;
      repeat (10) @(negedge clk);
      in_valid   = 1'b0;
      ready_mode = 1;
      drain();
      @(negedge clk);
      chk("bp_in_ready_after",  32'(in_ready),  32'd1);
      chk("bp_out_valid_after", 32'(out_valid), 32'd0);

      // Reset during BUSY drops the in-flight op.
      wait_in_ready();
      dividend = 16'hABCD;
      divisor  = 8'h12;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_in_ready",  32'(in_ready),    32'd1);
      chk("arst_out_valid", 32'(out_valid),   32'd0);
      chk("arst_quotient",  32'(quotient),    32'd0);
      chk("arst_remainder", 32'(remainder),   32'd0);
      chk("arst_dbz",       32'(div_by_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      send(16'd200, 8'd10, 16'd20, 8'd0, 1'b0);
      drain();

      // Random operands with random producer and consumer gaps.
      ready_mode = 2;
      for (int k = 0; k < 1500; k++) begin
         logic [15:0] x;
         logic [7:0]  y;
         x = 16'($urandom);
         y = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (y == 8'd0) send(x, y, 16'hFFFF, x[7:0], 1'b1);
         else           send(x, y, x / 16'(y), 8'(x % 16'(y)), 1'b0);
      end
      drain();
      ready_mode = 1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_500_000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
